// File: rtl/uart_pkg.sv
// Shared types and constants for the UART host-side FIFO controller.
package uart_pkg;

  localparam int UART_BUS_W = 32;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_WAIT
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_HOLD,
    R_CAP,
    R_ACK
  } rx_state_e;

  // 0->1 transition of a level signal against its registered previous value.
  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty come from an occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and the count do, and rdata is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Host-side UART controller: TX FIFO feeding the core's start/done handshake,
// RX FIFO filled from the core's done/ack handshake with back-pressure when full.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic                  tx_full_o,
  output logic                  tx_empty_o,
  output logic [LVL_W-1:0]      tx_level_o,
  output logic                  tx_ovf_o,
  input  logic                  rd_en_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_perr_o,
  output logic                  rx_empty_o,
  output logic                  rx_full_o,
  output logic [LVL_W-1:0]      rx_level_o,
  input  logic                  clr_ovf_i,
  output logic [UART_BUS_W-1:0] tx_data_o,
  output logic                  start_tx_o,
  input  logic                  tx_done_i,
  input  logic                  rx_done_i,
  input  logic [UART_BUS_W-1:0] rx_data_i,
  input  logic                  parity_error_i,
  output logic                  host_read_data_o
);

  tx_state_e         tx_state;
  rx_state_e         rx_state;
  logic              tx_done_prev;
  logic              rx_done_prev;
  logic              tx_pop;
  logic              tx_fifo_empty;
  logic [DATA_W-1:0] tx_head;
  logic              ovf_set;
  logic              rx_push;
  logic [DATA_W:0]   rx_wdata;
  logic [DATA_W:0]   rx_head;
  logic              rx_unused;

  // ---------------- TX path ----------------
  assign tx_pop     = (tx_state == T_IDLE) && !tx_fifo_empty;
  assign ovf_set    = wr_en_i && tx_full_o && !tx_pop;
  assign tx_empty_o = tx_fifo_empty && (tx_state == T_IDLE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en_i),
    .wdata (wr_data_i),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full_o),
    .empty (tx_fifo_empty),
    .level (tx_level_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= T_IDLE;
      tx_data_o    <= '0;
      start_tx_o   <= 1'b0;
      tx_done_prev <= 1'b0;
      tx_ovf_o     <= 1'b0;
    end else begin
      // NOTE: pulse outputs take a default here and are overridden below; with non-blocking assignment the last one wins.
      start_tx_o   <= 1'b0;
      tx_done_prev <= tx_done_i;
      if (ovf_set) begin
        tx_ovf_o <= 1'b1;
      end else if (clr_ovf_i) begin
        tx_ovf_o <= 1'b0;
      end
      case (tx_state)
        T_IDLE: begin
          if (tx_pop) begin
            tx_data_o <= {{(UART_BUS_W - DATA_W){1'b0}}, tx_head};
            tx_state  <= T_START;
          end
        end
        T_START: begin
          start_tx_o <= 1'b1;
          tx_state   <= T_WAIT;
        end
        T_WAIT: begin
          if (rising(tx_done_i, tx_done_prev)) tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  assign rx_push   = (rx_state == R_CAP);
  assign rx_wdata  = {parity_error_i, rx_data_i[DATA_W-1:0]};
  assign rd_data_o = rx_head[DATA_W-1:0];
  assign rd_perr_o = rx_head[DATA_W];
  assign rx_unused = ^rx_data_i[UART_BUS_W-1:DATA_W];

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_wdata),
    .pop   (rd_en_i),
    .rdata (rx_head),
    .full  (rx_full_o),
    .empty (rx_empty_o),
    .level (rx_level_o)
  );

  // Withholding the ack while full keeps the core's rts_n asserted toward the peer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state         <= R_IDLE;
      rx_done_prev     <= 1'b0;
      host_read_data_o <= 1'b0;
    end else begin
      host_read_data_o <= 1'b0;
      rx_done_prev     <= rx_done_i;
      case (rx_state)
        R_IDLE: begin
          if (rising(rx_done_i, rx_done_prev)) begin
            rx_state <= rx_full_o ? R_HOLD : R_CAP;
          end
        end
        R_HOLD: begin
          if (!rx_full_o) rx_state <= R_CAP;
        end
        R_CAP: rx_state <= R_ACK;
        R_ACK: begin
          host_read_data_o <= 1'b1;
          rx_state         <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: directed stimulus queues expectations, a monitor checks DUT outputs.
module tb_uart_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = 5;

  logic              clk;
  logic              rst;
  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              tx_full_o;
  logic              tx_empty_o;
  logic [LVL_W-1:0]  tx_level_o;
  logic              tx_ovf_o;
  logic              rd_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_perr_o;
  logic              rx_empty_o;
  logic              rx_full_o;
  logic [LVL_W-1:0]  rx_level_o;
  logic              clr_ovf_i;
  logic [31:0]       tx_data_o;
  logic              start_tx_o;
  logic              tx_done_i;
  logic              rx_done_i;
  logic [31:0]       rx_data_i;
  logic              parity_error_i;
  logic              host_read_data_o;

  uart_fifo_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en_i          (wr_en_i),
    .wr_data_i        (wr_data_i),
    .tx_full_o        (tx_full_o),
    .tx_empty_o       (tx_empty_o),
    .tx_level_o       (tx_level_o),
    .tx_ovf_o         (tx_ovf_o),
    .rd_en_i          (rd_en_i),
    .rd_data_o        (rd_data_o),
    .rd_perr_o        (rd_perr_o),
    .rx_empty_o       (rx_empty_o),
    .rx_full_o        (rx_full_o),
    .rx_level_o       (rx_level_o),
    .clr_ovf_i        (clr_ovf_i),
    .tx_data_o        (tx_data_o),
    .start_tx_o       (start_tx_o),
    .tx_done_i        (tx_done_i),
    .rx_done_i        (rx_done_i),
    .rx_data_i        (rx_data_i),
    .parity_error_i   (parity_error_i),
    .host_read_data_o (host_read_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          ack_cnt = 0;
  logic        core_auto = 1'b0;
  logic [31:0] tx_exp[$];
  logic [8:0]  rx_exp[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    tx_exp.push_back({24'h0, b});
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic rx_frame(input logic [31:0] d, input logic pe);
    rx_data_i      = d;
    parity_error_i = pe;
    rx_done_i      = 1'b1;
    rx_exp.push_back({pe, d[7:0]});
    step();
    rx_done_i = 1'b0;
  endtask

  task automatic host_pop();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  // Core model: answers each start_tx with a one-cycle tx_done 20 cycles later while enabled.
  initial begin
    int cnt;
    cnt       = -1;
    tx_done_i = 1'b0;
    forever begin
      step();
      tx_done_i = 1'b0;
      if (rst) cnt = -1;
      else if (start_tx_o) cnt = 20;
      else if (cnt > 0 && core_auto) cnt--;
      if (cnt == 0) begin
        tx_done_i = 1'b1;
        cnt       = -1;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT launches a frame or the host reads a head entry.
  initial begin
    logic prev_start;
    logic prev_ack;
    prev_start = 1'b0;
    prev_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start_tx_o) begin
          start_cnt++;
          check("start_tx_pulse_width", {31'h0, prev_start}, 32'h0);
          if (tx_exp.size() == 0) check("tx_unexpected_start", {31'h0, start_tx_o}, 32'h0);
          else check("tx_data", tx_data_o, tx_exp.pop_front());
        end
        if (rd_en_i && !rx_empty_o) begin
          if (rx_exp.size() == 0) check("rx_unexpected_head", {31'h0, rx_empty_o}, 32'h1);
          else check("rx_head", {23'h0, rd_perr_o, rd_data_o}, {23'h0, rx_exp.pop_front()});
        end
        if (host_read_data_o) begin
          ack_cnt++;
          check("ack_pulse_width", {31'h0, prev_ack}, 32'h0);
        end
      end
      prev_start = start_tx_o;
      prev_ack   = host_read_data_o;
    end
  end

  initial begin
    int n;
    int base;
    rst            = 1'b1;
    wr_en_i        = 1'b0;
    wr_data_i      = '0;
    rd_en_i        = 1'b0;
    clr_ovf_i      = 1'b0;
    rx_done_i      = 1'b0;
    rx_data_i      = '0;
    parity_error_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_empty", {31'h0, tx_empty_o}, 32'h1);
    check("rst_rx_empty", {31'h0, rx_empty_o}, 32'h1);
    check("rst_fulls", {30'h0, tx_full_o, rx_full_o}, 32'h0);
    check("rst_levels", {22'h0, tx_level_o, rx_level_o}, 32'h0);
    check("rst_ovf", {31'h0, tx_ovf_o}, 32'h0);
    check("rst_pulses", {30'h0, start_tx_o, host_read_data_o}, 32'h0);
    check("rst_tx_data", tx_data_o, 32'h0);
    check("rst_rd_head", {23'h0, rd_perr_o, rd_data_o}, 32'h0);

    // Two bytes through the core model.
    core_auto = 1'b1;
    base      = start_cnt;
    step();
    push_tx(8'h55);
    push_tx(8'hA3);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_empty_o && tx_exp.size() == 0 && start_cnt - base == 2) break;
    end
    check("tx_empty_after_done", {31'h0, tx_empty_o}, 32'h1);
    check("tx_two_starts", start_cnt - base, 32'd2);
    check("tx_data_holds", tx_data_o, 32'h0000_00A3);

    // 17 pushes with tx_done held off: one launches, 16 queue.
    core_auto = 1'b0;
    step();
    for (int i = 0; i < 17; i++) push_tx(8'h20 + 8'(i));
    @(negedge clk);
    check("tx_full_16", {27'h0, tx_level_o}, 32'd16);
    check("tx_full_flag", {31'h0, tx_full_o}, 32'h1);
    check("tx_no_ovf_17", {31'h0, tx_ovf_o}, 32'h0);
    step();
    wr_en_i   = 1'b1;
    wr_data_i = 8'hEE;
    step();
    wr_en_i = 1'b0;
    @(negedge clk);
    check("tx_ovf_set", {31'h0, tx_ovf_o}, 32'h1);
    check("tx_ovf_level", {27'h0, tx_level_o}, 32'd16);
    step();
    wr_en_i   = 1'b1;
    wr_data_i = 8'hEF;
    clr_ovf_i = 1'b1;
    step();
    wr_en_i = 1'b0;
    @(negedge clk);
    check("tx_ovf_set_wins", {31'h0, tx_ovf_o}, 32'h1);
    step();
    clr_ovf_i = 1'b0;
    @(negedge clk);
    check("tx_ovf_cleared", {31'h0, tx_ovf_o}, 32'h0);

    // Push while the FSM pops at full: both honoured.
    core_auto = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (tx_done_i) break;
    end
    check("tx_done_seen", {31'h0, tx_done_i}, 32'h1);
    step();
    push_tx(8'h99);
    @(negedge clk);
    check("tx_simul_level", {27'h0, tx_level_o}, 32'd16);
    check("tx_simul_no_ovf", {31'h0, tx_ovf_o}, 32'h0);
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (tx_empty_o) break;
    end
    check("tx_drained", {31'h0, tx_empty_o}, 32'h1);
    check("tx_all_sent", tx_exp.size(), 32'd0);

    // Single RX frame: ack three cycles after the edge.
    base = ack_cnt;
    step();
    rx_frame(32'h0000_01C3, 1'b1);
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      if (host_read_data_o) break;
      step();
      n++;
    end
    check("rx_ack_latency", n, 32'd3);
    check("rx_head_data", {24'h0, rd_data_o}, 32'hC3);
    check("rx_head_perr", {31'h0, rd_perr_o}, 32'h1);
    check("rx_level_1", {27'h0, rx_level_o}, 32'd1);
    step();
    host_pop();

    // Fill RX, then a 17th frame must wait for a pop.
    for (int k = 1; k <= 16; k++) begin
      rx_frame(32'hA5A5_A500 | k, k[0]);
      repeat (4) step();
    end
    @(negedge clk);
    check("rx_full_16", {27'h0, rx_level_o}, 32'd16);
    check("rx_full_flag", {31'h0, rx_full_o}, 32'h1);
    base = ack_cnt;
    step();
    rx_frame(32'h0000_005E, 1'b0);
    repeat (10) step();
    check("rx_hold_no_ack", ack_cnt - base, 32'd0);
    host_pop();
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (host_read_data_o) break;
      step();
    end
    check("rx_hold_ack", {31'h0, host_read_data_o}, 32'h1);
    check("rx_hold_level", {27'h0, rx_level_o}, 32'd16);

    // Host pop in the same cycle as the capture write.
    step();
    host_pop();
    step();
    rx_frame(32'h0000_0177, 1'b1);
    host_pop();
    @(negedge clk);
    check("rx_simul_level", {27'h0, rx_level_o}, 32'd15);
    repeat (3) step();
    check("rx_simul_level_after", {27'h0, rx_level_o}, 32'd15);
    for (int k = 0; k < 15; k++) host_pop();
    @(negedge clk);
    check("rx_drained", {31'h0, rx_empty_o}, 32'h1);
    check("rx_scoreboard_empty", rx_exp.size(), 32'd0);
    step();
    host_pop();
    @(negedge clk);
    check("rx_pop_empty_level", {27'h0, rx_level_o}, 32'd0);

    // Reset mid-frame with 5 bytes queued.
    step();
    rx_frame(32'h0000_0042, 1'b0);
    repeat (5) step();
    core_auto = 1'b0;
    for (int i = 0; i < 6; i++) push_tx(8'h60 + 8'(i));
    repeat (6) step();
    @(negedge clk);
    check("pre_rst_tx_level", {27'h0, tx_level_o}, 32'd5);
    check("pre_rst_rx_level", {27'h0, rx_level_o}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    base = start_cnt;
    @(negedge clk);
    check("mid_rst_tx_empty", {31'h0, tx_empty_o}, 32'h1);
    check("mid_rst_rx_empty", {31'h0, rx_empty_o}, 32'h1);
    check("mid_rst_levels", {22'h0, tx_level_o, rx_level_o}, 32'h0);
    check("mid_rst_fulls_ovf", {29'h0, tx_full_o, rx_full_o, tx_ovf_o}, 32'h0);
    check("mid_rst_pulses", {30'h0, start_tx_o, host_read_data_o}, 32'h0);
    check("mid_rst_tx_data", tx_data_o, 32'h0);
    check("mid_rst_rd_head", {23'h0, rd_perr_o, rd_data_o}, 32'h0);
    core_auto = 1'b1;
    repeat (40) step();
    check("no_start_after_rst", start_cnt - base, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Host-side counterpart of the UART core's register interface.
- Drives the core's transmit handshake (tx_data / start_tx / tx_done) from a TX FIFO.
- Consumes the core's receive handshake (rx_done / rx_data / parity_error / host_read_data) into an RX FIFO.
- Sits between the APB register block and the UART core, decoupling host access rate from line baud rate.

Parameters:
- DATA_W, 8: stored payload width; core data buses are 32 bits, upper bits zero on TX and ignored on RX.
- DEPTH, 16: entries per FIFO; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: width of the level outputs.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- wr_en_i  in  1  host push into TX FIFO.
- wr_data_i  in  DATA_W  host TX byte.
- tx_full_o  out  1  TX FIFO full.
- tx_empty_o  out  1  TX FIFO empty and no frame in flight.
- tx_level_o  out  LVL_W  TX FIFO occupancy.
- tx_ovf_o  out  1  sticky: push attempted while full.
- rd_en_i  in  1  host pop from RX FIFO.
- rd_data_o  out  DATA_W  RX FIFO head, first-word-fall-through.
- rd_perr_o  out  1  parity-error flag stored with the head entry.
- rx_empty_o  out  1  RX FIFO empty.
- rx_full_o  out  1  RX FIFO full.
- rx_level_o  out  LVL_W  RX FIFO occupancy.
- clr_ovf_i  in  1  clears tx_ovf_o.
- tx_data_o  out  32  to core: {zeros, byte}.
- start_tx_o  out  1  to core: one-cycle launch pulse.
- tx_done_i  in  1  from core: frame transmitted.
- rx_done_i  in  1  from core: frame received.
- rx_data_i  in  32  from core: received data; bits [DATA_W-1:0] used.
- parity_error_i  in  1  from core: parity error for the current frame.
- host_read_data_o  out  1  to core: one-cycle acknowledge of a received frame.

Behaviour:
- Reset values (synchronous on rst=1):
  - Both FIFOs empty, pointers 0, levels 0.
  - tx_empty_o=1, rx_empty_o=1, all full flags 0, tx_ovf_o=0.
  - start_tx_o=0, host_read_data_o=0, tx_data_o=0, rd_data_o=0, rd_perr_o=0.
  - Both FSMs in IDLE; edge-detect registers cleared.
- tx_done_i and rx_done_i are level-tolerant: only 0→1 transitions are acted on, using a registered previous value.
- TX FIFO push:
  - wr_en_i with not full: write and increment; level updates the next cycle.
  - wr_en_i while full: data dropped, tx_ovf_o set. clr_ovf_i clears it; a simultaneous set wins.
- TX FSM:
  - T_IDLE: if FIFO not empty, pop the head, register it on tx_data_o, go to T_START.
  - T_START: start_tx_o=1 for exactly one cycle, go to T_WAIT.
  - T_WAIT: on tx_done_i rising edge, go to T_IDLE. The next pop can happen on the following cycle.
  - tx_data_o holds stable from T_START until the next pop.
- Push and pop in the same cycle are both honoured, including when full (pop frees a slot): level unchanged, no ovf.
- RX FSM:
  - R_IDLE: on rx_done_i rising edge, go to R_CAP if the FIFO is not full, else R_HOLD.
  - R_HOLD: wait for the FIFO to become not full, then R_CAP. The core is not acknowledged, so its rts_n stays asserted and back-pressures the peer.
  - R_CAP: write {parity_error_i, rx_data_i[DATA_W-1:0]}, go to R_ACK.
  - R_ACK: host_read_data_o=1 for one cycle, go to R_IDLE.
  - Frame-to-ack latency with space available is 3 cycles after the edge.
- RX FIFO pop:
  - rd_en_i with not empty advances the head; rd_data_o and rd_perr_o show the new head the next cycle.
  - rd_en_i while empty is ignored; outputs hold.
  - A host pop and an R_CAP write in the same cycle are both honoured.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from an occupancy counter, not the pointers.
- A full cycle of DEPTH pushes and DEPTH pops must return all levels to 0 with pointers back at their start.
- rst asserted mid-frame: FSMs abort to IDLE and FIFO contents are discarded. The core is reset by the same system and is not otherwise notified.

Decomposition:
- uart_pkg holds: the tx_state_e {T_IDLE, T_START, T_WAIT} and rx_state_e {R_IDLE, R_HOLD, R_CAP, R_ACK} typedefs, and the UART_BUS_W=32 constant.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/level) is instantiated twice: TX at width DATA_W, RX at width DATA_W+1.

Test Plan:
- Push 0x55, 0xA3 with core model returning tx_done 20 cycles after each start.
  - Required: two start_tx_o pulses, tx_data_o=0x00000055 then 0x000000A3.
  - Required: tx_empty_o=1 after the second done.
- Push 17 bytes into DEPTH=16 with tx_done held low.
  - Required: the first byte launches and 16 queue, so no overflow.
  - Then push 1 more. Required: the 18th push sets tx_ovf_o; clr_ovf_i clears it.
- rx_done pulse with rx_data_i=0x1C3, parity_error_i=1.
  - Required: host_read_data_o pulses 3 cycles later.
  - Required: rd_data_o=0xC3, rd_perr_o=1, rx_level_o=1.
- Fill RX to 16, then raise rx_done.
  - Required: no host_read_data_o until one rd_en_i pop.
  - Then required: capture, then ack; level returns to 16.
- Simultaneous wr_en_i and TX pop at full, and rd_en_i with R_CAP.
  - Required: levels unchanged, no ovf, data order preserved.
- Assert rst during T_WAIT with 5 bytes queued.
  - Required: all outputs at reset values the next cycle, levels 0, no further start_tx_o.
